// File: rtl/dmi_req_sequencer.sv
// DMI request sequencer: turns one DMI request into one debug-module register
// access, bounded by a timeout, and returns the DMI response.
module dmi_req_sequencer #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             dmi_req_vld,
    input  logic [ADDR_WIDTH+DATA_WIDTH+1:0] dmi_req_pld,
    output logic                             dmi_req_rdy,
    output logic                             reg_req_vld,
    output logic                             reg_req_wr,
    output logic [ADDR_WIDTH-1:0]            reg_req_addr,
    output logic [DATA_WIDTH-1:0]            reg_req_wdata,
    input  logic                             reg_req_rdy,
    input  logic                             reg_rsp_vld,
    input  logic [DATA_WIDTH-1:0]            reg_rsp_rdata,
    input  logic                             reg_rsp_err,
    output logic                             reg_abort,
    output logic                             dmi_rsp_vld,
    output logic [DATA_WIDTH+1:0]            dmi_rsp_pld,
    input  logic                             dmi_rsp_rdy
);

    localparam int unsigned REQ_W = ADDR_WIDTH + DATA_WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  abort_q, abort_d;

    logic                  cnt_at_max;
    logic [CNT_W-1:0]      cnt_inc;

    // Budget is shared by REQ and WAIT; the counter saturates once spent so a
    // late REQ completion leaves no slack for WAIT.
    assign cnt_at_max = (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_resp_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_resp_q <= rsp_resp_d;
            abort_q    <= abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_resp_d = rsp_resp_q;
        abort_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmi_req_vld) begin
                    addr_d     = dmi_req_pld[REQ_W-1 -: ADDR_WIDTH];
                    data_d     = dmi_req_pld[DATA_WIDTH+1:2];
                    op_d       = dmi_req_pld[1:0];
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    case (dmi_req_pld[1:0])
                        OP_NOP: begin
                            state_d    = ST_RSP;
                            rsp_resp_d = RESP_OK;
                        end
                        OP_READ, OP_WRITE: begin
                            state_d = ST_REQ;
                        end
                        default: begin
                            state_d    = ST_RSP;
                            rsp_resp_d = RESP_FAIL;
                        end
                    endcase
                end
            end
            ST_REQ: begin
                if (reg_req_rdy) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_inc;
                end else if (cnt_at_max) begin
                    state_d    = ST_RSP;
                    rsp_data_d = '0;
                    rsp_resp_d = RESP_FAIL;
                    abort_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WAIT: begin
                if (reg_rsp_vld) begin
                    state_d    = ST_RSP;
                    rsp_data_d = (op_q == OP_READ) ? reg_rsp_rdata : '0;
                    rsp_resp_d = reg_rsp_err ? RESP_FAIL : RESP_OK;
                end else if (cnt_at_max) begin
                    state_d    = ST_RSP;
                    rsp_data_d = '0;
                    rsp_resp_d = RESP_FAIL;
                    abort_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RSP: begin
                if (dmi_rsp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state and latched fields
    always_comb begin
        dmi_req_rdy   = 1'b0;
        reg_req_vld   = 1'b0;
        dmi_rsp_vld   = 1'b0;
        reg_req_wr    = (op_q == OP_WRITE);
        reg_req_addr  = addr_q;
        reg_req_wdata = data_q;
        reg_abort     = abort_q;
        dmi_rsp_pld   = {rsp_data_q, rsp_resp_q};
        case (state_q)
            ST_IDLE: dmi_req_rdy = 1'b1;
            ST_REQ:  reg_req_vld = 1'b1;
            ST_RSP:  dmi_rsp_vld = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmi_req_sequencer.sv
// Randomized bench for dmi_req_sequencer against a transaction-level model
// of request decode, register-bus timing budget and response formation.
module tb_dmi_req_sequencer;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;
    localparam int unsigned T  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dmi_req_vld;
    logic [AW+DW+1:0]  dmi_req_pld;
    logic              dmi_req_rdy;
    logic              reg_req_vld;
    logic              reg_req_wr;
    logic [AW-1:0]     reg_req_addr;
    logic [DW-1:0]     reg_req_wdata;
    logic              reg_req_rdy;
    logic              reg_rsp_vld;
    logic [DW-1:0]     reg_rsp_rdata;
    logic              reg_rsp_err;
    logic              reg_abort;
    logic              dmi_rsp_vld;
    logic [DW+1:0]     dmi_rsp_pld;
    logic              dmi_rsp_rdy;

    int total = 0;
    int bad   = 0;

    dmi_req_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmi_req_vld   (dmi_req_vld),
        .dmi_req_pld   (dmi_req_pld),
        .dmi_req_rdy   (dmi_req_rdy),
        .reg_req_vld   (reg_req_vld),
        .reg_req_wr    (reg_req_wr),
        .reg_req_addr  (reg_req_addr),
        .reg_req_wdata (reg_req_wdata),
        .reg_req_rdy   (reg_req_rdy),
        .reg_rsp_vld   (reg_rsp_vld),
        .reg_rsp_rdata (reg_rsp_rdata),
        .reg_rsp_err   (reg_rsp_err),
        .reg_abort     (reg_abort),
        .dmi_rsp_vld   (dmi_rsp_vld),
        .dmi_rsp_pld   (dmi_rsp_pld),
        .dmi_rsp_rdy   (dmi_rsp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Budget of T+1 REQ/WAIT edges; completion on the last budget edge wins,
    // and a REQ completion on that edge leaves only one WAIT edge.
    function automatic bit will_time_out(input int d1, input int d2);
        if (d1 > int'(T)) return 1'b1;
        if (d1 == int'(T)) return (d2 > 0);
        return (d1 + 1 + d2) > int'(T);
    endfunction

    function automatic logic [DW+1:0] exp_rsp(input logic [1:0] op, input logic [DW-1:0] rdata,
                                              input logic err, input bit tout);
        if (op == 2'd0) return {{DW{1'b0}}, 2'd0};
        if (op == 2'd3) return {{DW{1'b0}}, 2'd2};
        if (tout)       return {{DW{1'b0}}, 2'd2};
        if (op == 2'd1) return {rdata, err ? 2'd2 : 2'd0};
        return {{DW{1'b0}}, err ? 2'd2 : 2'd0};
    endfunction

    // d1: cycles before reg_req_rdy, d2: cycles in WAIT before rsp, d3: cycles of rsp backpressure
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int d1, input int d2, input int d3,
                           input logic [DW-1:0] rdata, input logic err, input bit late);
        bit              is_acc;
        bit              tout;
        int              nwait;
        int              waited;
        logic [DW+1:0]   exp;
        logic [AW+DW:0]  exp_fields;
        waited = 0;
        while (!dmi_req_rdy && waited < 20) begin
            tick();
            waited++;
        end
        check_eq("idle_req_rdy", 64'(dmi_req_rdy), 64'd1);
        is_acc     = (op == 2'd1) || (op == 2'd2);
        tout       = is_acc && will_time_out(d1, d2);
        exp        = exp_rsp(op, rdata, err, tout);
        exp_fields = {(op == 2'd2), addr, data};
        dmi_req_vld = 1'b1;
        dmi_req_pld = {addr, data, op};
        tick();
        dmi_req_vld = 1'b0;
        if (is_acc) begin
            for (int k = 0; k <= d1 && k <= int'(T); k++) begin
                check_eq("reg_req_vld", 64'(reg_req_vld), 64'd1);
                check_eq("reg_req_fields", 64'({reg_req_wr, reg_req_addr, reg_req_wdata}), 64'(exp_fields));
                check_eq("busy_req_rdy", 64'(dmi_req_rdy), 64'd0);
                reg_req_rdy = (k == d1);
                tick();
            end
            reg_req_rdy = 1'b0;
            if (d1 <= int'(T)) begin
                nwait = tout ? ((d1 == int'(T)) ? 1 : int'(T) - d1) : d2 + 1;
                for (int j = 0; j < nwait; j++) begin
                    check_eq("wait_req_vld", 64'(reg_req_vld), 64'd0);
                    check_eq("wait_rsp_vld", 64'(dmi_rsp_vld), 64'd0);
                    reg_rsp_vld   = (j == d2);
                    reg_rsp_rdata = (j == d2) ? rdata : $urandom;
                    reg_rsp_err   = (j == d2) ? err : 1'($urandom);
                    tick();
                end
                reg_rsp_vld = 1'b0;
            end
        end
        for (int j = 0; j <= d3; j++) begin
            check_eq("rsp_vld", 64'(dmi_rsp_vld), 64'd1);
            check_eq("rsp_pld", 64'(dmi_rsp_pld), 64'(exp));
            check_eq("abort", 64'(reg_abort), 64'(j == 0 && tout));
            check_eq("rsp_req_vld", 64'(reg_req_vld), 64'd0);
            check_eq("rsp_req_rdy", 64'(dmi_req_rdy), 64'd0);
            dmi_req_vld   = (j < d3) ? 1'($urandom) : 1'b0;
            dmi_req_pld   = {$urandom, $urandom};
            reg_rsp_vld   = late && tout && (j == 0);
            reg_rsp_rdata = $urandom;
            reg_rsp_err   = 1'b0;
            dmi_rsp_rdy   = (j == d3);
            tick();
        end
        dmi_rsp_rdy = 1'b0;
        dmi_req_vld = 1'b0;
        reg_rsp_vld = 1'b0;
        check_eq("post_rsp_vld", 64'(dmi_rsp_vld), 64'd0);
        check_eq("post_req_rdy", 64'(dmi_req_rdy), 64'd1);
        check_eq("post_abort", 64'(reg_abort), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        dmi_req_vld   = 1'b0;
        dmi_req_pld   = '0;
        reg_req_rdy   = 1'b0;
        reg_rsp_vld   = 1'b0;
        reg_rsp_rdata = '0;
        reg_rsp_err   = 1'b0;
        dmi_rsp_rdy   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_req_rdy", 64'(dmi_req_rdy), 64'd1);
        check_eq("rst_reg_req_vld", 64'(reg_req_vld), 64'd0);
        check_eq("rst_rsp_vld", 64'(dmi_rsp_vld), 64'd0);
        check_eq("rst_abort", 64'(reg_abort), 64'd0);
        check_eq("rst_rsp_pld", 64'(dmi_rsp_pld), 64'd0);

        run_txn(2'd1, 7'h11, 32'h0, 0, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
        run_txn(2'd2, 7'h10, 32'h1, 1, 1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_txn(2'd0, 7'h05, 32'h1234, 0, 0, 0, 32'h0, 1'b0, 1'b0);
        run_txn(2'd3, 7'h06, 32'h5678, 0, 0, 1, 32'h0, 1'b0, 1'b0);
        run_txn(2'd1, 7'h22, 32'h0, 10, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b1);
        run_txn(2'd1, 7'h23, 32'h0, 0, 1, 0, 32'h0BAD_CAFE, 1'b0, 1'b0);
        run_txn(2'd1, 7'h24, 32'h0, 1, 5, 0, 32'h1111_2222, 1'b0, 1'b1);
        run_txn(2'd1, 7'h25, 32'h0, 1, 2, 0, 32'h3333_4444, 1'b0, 1'b0);
        run_txn(2'd1, 7'h26, 32'h0, int'(T), 0, 0, 32'h5555_6666, 1'b1, 1'b0);
        run_txn(2'd2, 7'h27, 32'hA5A5, int'(T), 1, 0, 32'h0, 1'b0, 1'b1);
        run_txn(2'd1, 7'h28, 32'h0, 0, 0, 10, 32'h7777_8888, 1'b0, 1'b0);

        // Reset while WAITing drops the access and emits no response
        dmi_req_vld = 1'b1;
        dmi_req_pld = {7'h30, 32'h0, 2'd1};
        tick();
        dmi_req_vld = 1'b0;
        reg_req_rdy = 1'b1;
        tick();
        reg_req_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_req_rdy", 64'(dmi_req_rdy), 64'd1);
        check_eq("mid_rst_reg_req_vld", 64'(reg_req_vld), 64'd0);
        check_eq("mid_rst_rsp_vld", 64'(dmi_rsp_vld), 64'd0);
        check_eq("mid_rst_rsp_pld", 64'(dmi_rsp_pld), 64'd0);
        check_eq("mid_rst_abort", 64'(reg_abort), 64'd0);
        for (int i = 0; i < 6; i++) begin
            reg_rsp_vld   = (i == 0);
            reg_rsp_rdata = 32'h9999_9999;
            tick();
            check_eq("post_rst_no_rsp", 64'(dmi_rsp_vld), 64'd0);
        end
        reg_rsp_vld = 1'b0;

        for (int n = 0; n < 60; n++) begin
            run_txn(2'($urandom_range(0, 3)), 7'($urandom), $urandom,
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
